// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  // Arbiter ownership states: free arbitration, or locked to one master
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Master indices into the two-bit request/grant vectors
  localparam int M_CPU = 0;
  localparam int M_DBG = 1;

  // Default bus widths (256x8 memory)
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: master-side request/response signals plus memory pins.
// The slave modport is the arbiter's view; the master modport is the
// environment (processor, debug loader and memory) view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              m0_req,   m1_req;
  logic              m0_we,    m1_we;
  logic              m0_lock,  m1_lock;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt,   m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              m0_stall;
  logic              MemRead, MemWrite;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_in;
  logic [DATA_W-1:0] Data_out;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  Data_out,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata, m0_stall,
    output MemRead, MemWrite, ADDR, Data_in
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output Data_out,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata, m0_stall,
    input  MemRead, MemWrite, ADDR, Data_in
  );

endinterface

// File: rtl/arb_pick2.sv
// arb_pick2: two-request picker. With MEM_ARBITER_RR_EN defined a one-bit
// pointer breaks ties and moves to favour the other master after every
// grant; otherwise m0 always wins ties and no pointer is built.
// upd_ptr flags that a grant was issued this cycle.
module arb_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] gnt_oh,
  output logic [1:0] win_oh,
  output logic       upd_ptr
);

  assign upd_ptr = |gnt_oh;

`ifdef MEM_ARBITER_RR_EN
  logic ptr_r;  // 0: m0 favoured on a tie, 1: m1 favoured

  // Pointer moves to favour whichever master was not just granted
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 1'b0;
    end else if (upd_ptr) begin
      ptr_r <= gnt_oh[M_CPU];
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Round-robin pick: single requester wins, pointer settles ties
  always_comb begin
    win_oh = 2'b00;
    case (req)
      2'b01:   win_oh = 2'b01;
      2'b10:   win_oh = 2'b10;
      2'b11:   win_oh = ptr_r ? 2'b10 : 2'b01;
      default: win_oh = 2'b00;
    endcase
  end
`else
  logic unused_s;
  assign unused_s = clk ^ reset;

  // Fixed-priority pick: the processor always wins a tie
  always_comb begin
    win_oh = 2'b00;
    if (req[M_CPU]) begin
      win_oh = 2'b01;
    end else if (req[M_DBG]) begin
      win_oh = 2'b10;
    end else begin
      win_oh = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous memory between the
// processor (m0) and the debug loader (m1). Grants are combinational,
// a lock keeps ownership across read-modify-write sequences, and read
// data returns one cycle after the grant with a per-master valid strobe.
// Build option: MEM_ARBITER_RR_EN selects round-robin tie breaking.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic            CLOCK_50,
  input logic            reset,
  mem_arbiter_if.slave   bus
);

  arb_state_e        state_r, state_next_s;
  logic [1:0]        req_s, win_s, gnt_s;
  logic              any_gnt_s;
  logic              we_sel_s;
  logic [ADDR_W-1:0] addr_sel_s;
  logic [DATA_W-1:0] wdata_sel_s;
  logic              rd_r;     // a read was granted last cycle
  logic              owner_r;  // which master that read belongs to

  assign req_s = {bus.m1_req, bus.m0_req};

  arb_pick2 u_pick (
    .clk     (CLOCK_50),
    .reset   (reset),
    .req     (req_s),
    .gnt_oh  (gnt_s),
    .win_oh  (win_s),
    .upd_ptr (any_gnt_s)
  );

  // Ownership state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Grant selection and lock transitions; reset blocks every grant
  always_comb begin
    gnt_s        = 2'b00;
    state_next_s = state_r;
    if (reset) begin
      gnt_s        = 2'b00;
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          gnt_s = win_s;
          if (win_s[M_CPU] && bus.m0_lock) begin
            state_next_s = OWN0;
          end else if (win_s[M_DBG] && bus.m1_lock) begin
            state_next_s = OWN1;
          end else begin
            state_next_s = IDLE;
          end
        end
        OWN0: begin
          gnt_s        = {1'b0, bus.m0_req};
          state_next_s = bus.m0_lock ? OWN0 : IDLE;
        end
        OWN1: begin
          gnt_s        = {bus.m1_req, 1'b0};
          state_next_s = bus.m1_lock ? OWN1 : IDLE;
        end
        default: begin
          gnt_s        = 2'b00;
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Memory mux: winner drives the pins, m0 drives them when nobody wins
  always_comb begin
    addr_sel_s  = bus.m0_addr;
    wdata_sel_s = bus.m0_wdata;
    we_sel_s    = bus.m0_we;
    if (gnt_s[M_DBG]) begin
      addr_sel_s  = bus.m1_addr;
      wdata_sel_s = bus.m1_wdata;
      we_sel_s    = bus.m1_we;
    end else begin
      addr_sel_s  = bus.m0_addr;
      wdata_sel_s = bus.m0_wdata;
      we_sel_s    = bus.m0_we;
    end
  end

  assign bus.ADDR     = addr_sel_s;
  assign bus.Data_in  = wdata_sel_s;
  assign bus.MemWrite = any_gnt_s & we_sel_s;
  assign bus.MemRead  = any_gnt_s & ~we_sel_s;
  assign bus.m0_gnt   = gnt_s[M_CPU];
  assign bus.m1_gnt   = gnt_s[M_DBG];
  assign bus.m0_stall = bus.m0_req & ~gnt_s[M_CPU];

  // Read-return tag: remember a granted read and its owner for one cycle
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_r    <= 1'b0;
      owner_r <= 1'b0;
    end else begin
      rd_r    <= any_gnt_s & ~we_sel_s;
      owner_r <= gnt_s[M_DBG];
    end
  end

  assign bus.m0_rvalid = rd_r & ~owner_r;
  assign bus.m1_rvalid = rd_r & owner_r;
  assign bus.rdata     = bus.Data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random stimulus for mem_arbiter. A
// behavioural model (owner index, tie pointer, memory array) predicts each
// cycle's grant and queues expected read returns; a separate monitor
// matches returns against that queue.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #5 CLOCK_50 = ~CLOCK_50;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    int         cyc;
    int         m;
    logic [7:0] d;
  } rexp_t;

  rexp_t      exp_q[$];
  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  bit         ram_loaded = 1'b0;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  int         owner  = -1;
`ifdef MEM_ARBITER_RR_EN
  int         favour = 0;
`endif

  function automatic logic [7:0] init_val(int i);
    logic [7:0] v;
    v = 8'((i * 37) + 11);
    if (i == 3) v = 8'h5A;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Cycle counter
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Synchronous 256x8 memory with registered read data
  always @(posedge CLOCK_50) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else begin
      if (bus.MemWrite) ram[bus.ADDR] <= bus.Data_in;
      if (bus.MemRead) bus.Data_out <= ram[bus.ADDR];
    end
  end

  // Reference model: predict grant and memory pins, then advance
  logic [1:0] eg;
  int         w;
  logic       mwe, mlk;
  logic [7:0] ma, md;
  always @(negedge CLOCK_50) begin
    eg = 2'b00;
    if (reset) eg = 2'b00;
    else if (owner == 0) eg = {1'b0, bus.m0_req};
    else if (owner == 1) eg = {bus.m1_req, 1'b0};
    else if (bus.m0_req && bus.m1_req) begin
`ifdef MEM_ARBITER_RR_EN
      eg = (favour == 0) ? 2'b01 : 2'b10;
`else
      eg = 2'b01;
`endif
    end else eg = {bus.m1_req, bus.m0_req};

    check("grant", {30'd0, bus.m1_gnt, bus.m0_gnt}, {30'd0, eg});
    check("m0_stall", {31'd0, bus.m0_stall}, {31'd0, bus.m0_req & ~eg[0]});
    w = 0; mlk = 1'b0;
    if (eg != 2'b00) begin
      w   = eg[1] ? 1 : 0;
      mwe = w ? bus.m1_we : bus.m0_we;
      ma  = w ? bus.m1_addr : bus.m0_addr;
      md  = w ? bus.m1_wdata : bus.m0_wdata;
      mlk = w ? bus.m1_lock : bus.m0_lock;
      check("mem_addr", {24'd0, bus.ADDR}, {24'd0, ma});
      check("mem_strobes", {30'd0, bus.MemWrite, bus.MemRead}, {30'd0, mwe, ~mwe});
      if (mwe) begin
        check("mem_wdata", {24'd0, bus.Data_in}, {24'd0, md});
        ref_mem[ma] = md;
      end else begin
        exp_q.push_back('{cyc + 1, w, ref_mem[ma]});
      end
    end else begin
      check("mem_idle", {30'd0, bus.MemWrite, bus.MemRead}, 32'd0);
    end

    if (reset) begin
      owner = -1;
`ifdef MEM_ARBITER_RR_EN
      favour = 0;
`endif
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    end else begin
`ifdef MEM_ARBITER_RR_EN
      if (eg != 2'b00) favour = 1 - w;
`endif
      if (owner < 0) begin
        if (eg != 2'b00 && mlk) owner = w;
      end else if ((owner == 0 && !bus.m0_lock) || (owner == 1 && !bus.m1_lock)) begin
        owner = -1;
      end
    end
  end

  // Monitor: match every read return against the expectation queue
  rexp_t e;
  always @(negedge CLOCK_50) begin
    if (bus.m0_rvalid === 1'b1 || bus.m1_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_cycle", cyc, e.cyc);
        check("rvalid_owner", {30'd0, bus.m1_rvalid, bus.m0_rvalid},
              (e.m == 1) ? 32'd2 : 32'd1);
        check("rdata", {24'd0, bus.rdata}, {24'd0, e.d});
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("missing_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid},
            (e.m == 1) ? 32'd2 : 32'd1);
    end
  end

  task automatic set_m0(bit r, bit we, bit lk, logic [7:0] a, logic [7:0] d);
    bus.m0_req = r; bus.m0_we = we; bus.m0_lock = lk; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(bit r, bit we, bit lk, logic [7:0] a, logic [7:0] d);
    bus.m1_req = r; bus.m1_we = we; bus.m1_lock = lk; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    step(3);
    reset = 1'b0;
    step(1);

    // m0 single read of 0x03
    set_m0(1'b1, 1'b0, 1'b0, 8'h03, 8'h00); step(1);
    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step(2);

    // both masters read every cycle
    set_m0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    set_m1(1'b1, 1'b0, 1'b0, 8'h20, 8'h00); step(6);
    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step(2);

    // read-modify-write by m1 under lock, including an idle locked cycle
    set_m1(1'b1, 1'b0, 1'b1, 8'h40, 8'h00); step(1);
    set_m0(1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
    set_m1(1'b0, 1'b0, 1'b1, 8'h40, 8'h00); step(1);
    set_m1(1'b1, 1'b1, 1'b0, 8'h40, 8'h41); step(1);
    set_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step(2);
    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step(2);

    // write then immediate read-back of 0x80
    set_m1(1'b1, 1'b1, 1'b0, 8'h80, 8'hC3); step(1);
    set_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m0(1'b1, 1'b0, 1'b0, 8'h80, 8'h00); step(1);
    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step(2);

    // reset while m1 owns the lock with a read outstanding
    set_m1(1'b1, 1'b0, 1'b1, 8'h50, 8'h00); step(1);
    reset = 1'b1;
    set_m0(1'b1, 1'b0, 1'b0, 8'h60, 8'h00); step(1);
    reset = 1'b0; step(1);
    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step(2);

    // randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      set_m0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, 8'($urandom_range(0, 31)), 8'($urandom));
      set_m1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, 8'($urandom_range(0, 31)), 8'($urandom));
      step(1);
    end
    reset = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(4);

    check("queue_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 256; i++) check("mem_contents", {24'd0, ram[i]}, {24'd0, ref_mem[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
